// File: rtl/sram_1p_march_bist_ctrl.sv
// sram_1p_march_bist_ctrl: March C- BIST engine driving the SRAM BIST port and checking A_DOUT.
// Optional BIST_CKBD_EN adds a checkerboard pass (0x55/0xAA); FAIL_ELEM then widens to {pass, elem}.
module sram_1p_march_bist_ctrl #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 12
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RST_N,
    input  logic                    START,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
`ifdef BIST_CKBD_EN
    output logic [3:0]              FAIL_ELEM,
`else
    output logic [2:0]              FAIL_ELEM,
`endif
    output logic [P_DATA_WIDTH-1:0] FAIL_SYND,
    output logic [7:0]              ERR_CNT,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);
`ifdef BIST_CKBD_EN
    localparam int LP_EW = 4;
`else
    localparam int LP_EW = 3;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                  r_state, w_state;
    logic [2:0]              r_elem, w_elem, w_ce;
    logic [P_ADDR_WIDTH-1:0] r_addr, w_addr, w_ca;
    logic                    r_ph, w_ph, w_cp;
    logic                    r_last, w_last, r_fcnt, w_fcnt, r_busy, w_busy;
    logic                    r_men, w_men, r_wen, w_wen, r_ren, w_ren;
    logic [P_ADDR_WIDTH-1:0] r_baddr, w_baddr;
    logic [P_DATA_WIDTH-1:0] r_din, w_din;
    logic                    r_s1_v, w_s1_v, r_s2_v;
    logic [P_DATA_WIDTH-1:0] r_s1_exp, w_s1_exp, r_s2_exp;
    logic [P_ADDR_WIDTH-1:0] r_s1_addr, w_s1_addr, r_s2_addr;
    logic [LP_EW-1:0]        r_s1_tag, w_s1_tag, r_s2_tag;
    logic                    r_fail, w_fail;
    logic [P_ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr;
    logic [LP_EW-1:0]        r_fail_elem, w_fail_elem;
    logic [P_DATA_WIDTH-1:0] r_fail_synd, w_fail_synd;
    logic [7:0]              r_err, w_err;
    logic                    w_issue, w_clr, w_rd, w_two, w_down, w_end, w_cpass, w_mis;
    logic [P_DATA_WIDTH-1:0] w_bg;
`ifdef BIST_CKBD_EN
    logic                    r_pass, w_pass;

    function automatic logic [P_DATA_WIDTH-1:0] f_ck();
        for (int i = 0; i < P_DATA_WIDTH; i++) f_ck[i] = (i % 2) == 0;
    endfunction
`endif

    // Counters hold the next op to issue; a START forces them back to op 0.
    always_comb begin
        w_state   = r_state;
        w_elem    = r_elem;
        w_addr    = r_addr;
        w_ph      = r_ph;
        w_last    = r_last;
        w_fcnt    = r_fcnt;
        w_busy    = r_busy;
        w_men     = 1'b0;
        w_wen     = 1'b0;
        w_ren     = 1'b0;
        w_baddr   = r_baddr;
        w_din     = r_din;
        w_s1_v    = 1'b0;
        w_s1_exp  = r_s1_exp;
        w_s1_addr = r_s1_addr;
        w_s1_tag  = r_s1_tag;
        w_issue   = 1'b0;
        w_clr     = 1'b0;
`ifdef BIST_CKBD_EN
        w_pass    = r_pass;
`endif
        case (r_state)
            S_IDLE, S_DONE: if (START) begin
                w_state = S_RUN;
                w_busy  = 1'b1;
                w_issue = 1'b1;
                w_clr   = 1'b1;
            end
            S_RUN: begin
                w_state = r_last ? S_FLUSH : S_RUN;
                w_issue = !r_last;
            end
            S_FLUSH: begin
                w_fcnt = !r_fcnt;
                if (r_fcnt) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_ce    = w_clr ? 3'd0 : r_elem;
        w_ca    = w_clr ? '0 : r_addr;
        w_cp    = w_clr ? 1'b0 : r_ph;
`ifdef BIST_CKBD_EN
        w_cpass = w_clr ? 1'b0 : r_pass;
        w_bg    = w_cpass ? f_ck() : '0;
`else
        w_cpass = 1'b1;
        w_bg    = '0;
`endif
        w_rd    = (w_ce != 3'd0) && !w_cp;
        w_two   = (w_ce != 3'd0) && (w_ce != 3'd5);
        w_down  = (w_ce == 3'd3) || (w_ce == 3'd4);
        w_end   = w_down ? (w_ca == '0) : (w_ca == '1);
        if (w_issue) begin
            w_men     = 1'b1;
            w_wen     = !w_rd;
            w_ren     = w_rd;
            w_baddr   = w_ca;
            w_din     = w_rd ? r_din : (((w_ce == 3'd1) || (w_ce == 3'd3)) ? ~w_bg : w_bg);
            w_s1_v    = w_rd;
            w_s1_exp  = ((w_ce == 3'd2) || (w_ce == 3'd4)) ? ~w_bg : w_bg;
            w_s1_addr = w_ca;
`ifdef BIST_CKBD_EN
            w_s1_tag  = {w_cpass, w_ce};
            w_pass    = w_cpass ^ (!(w_two && !w_cp) && w_end && (w_ce == 3'd5));
`else
            w_s1_tag  = w_ce;
`endif
            w_ph      = w_two && !w_cp;
            w_elem    = (w_ph || !w_end) ? w_ce : ((w_ce == 3'd5) ? 3'd0 : w_ce + 3'd1);
            w_addr    = w_ph ? w_ca : !w_end ? (w_down ? w_ca - 1'b1 : w_ca + 1'b1) :
                        ((w_ce == 3'd2) || (w_ce == 3'd3)) ? '1 : '0;
            w_last    = !w_ph && w_end && (w_ce == 3'd5) && w_cpass;
        end
    end

    always_comb begin
        w_mis       = r_s2_v && (A_DOUT != r_s2_exp);
        w_fail      = !w_clr && (r_fail || w_mis);
        w_fail_addr = w_clr ? '0 : (w_mis && !r_fail) ? r_s2_addr : r_fail_addr;
        w_fail_elem = w_clr ? '0 : (w_mis && !r_fail) ? r_s2_tag : r_fail_elem;
        w_fail_synd = w_clr ? '0 : (w_mis && !r_fail) ? (A_DOUT ^ r_s2_exp) : r_fail_synd;
        w_err       = w_clr ? 8'd0 : r_err + {7'd0, w_mis && (r_err != 8'hFF)};
    end

    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            r_state     <= S_IDLE;
            r_elem      <= '0;
            r_addr      <= '0;
            r_ph        <= 1'b0;
            r_last      <= 1'b0;
            r_fcnt      <= 1'b0;
            r_busy      <= 1'b0;
            r_men       <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_baddr     <= '0;
            r_din       <= '0;
            r_s1_v      <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_addr   <= '0;
            r_s1_tag    <= '0;
            r_s2_v      <= 1'b0;
            r_s2_exp    <= '0;
            r_s2_addr   <= '0;
            r_s2_tag    <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_synd <= '0;
            r_err       <= '0;
`ifdef BIST_CKBD_EN
            r_pass      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_elem      <= w_elem;
            r_addr      <= w_addr;
            r_ph        <= w_ph;
            r_last      <= w_last;
            r_fcnt      <= w_fcnt;
            r_busy      <= w_busy;
            r_men       <= w_men;
            r_wen       <= w_wen;
            r_ren       <= w_ren;
            r_baddr     <= w_baddr;
            r_din       <= w_din;
            r_s1_v      <= w_s1_v;
            r_s1_exp    <= w_s1_exp;
            r_s1_addr   <= w_s1_addr;
            r_s1_tag    <= w_s1_tag;
            r_s2_v      <= r_s1_v;
            r_s2_exp    <= r_s1_exp;
            r_s2_addr   <= r_s1_addr;
            r_s2_tag    <= r_s1_tag;
            r_fail      <= w_fail;
            r_fail_addr <= w_fail_addr;
            r_fail_elem <= w_fail_elem;
            r_fail_synd <= w_fail_synd;
            r_err       <= w_err;
`ifdef BIST_CKBD_EN
            r_pass      <= w_pass;
`endif
        end
    end

    assign BUSY        = r_busy;
    assign DONE        = r_state == S_DONE;
    assign FAIL        = r_fail;
    assign FAIL_ADDR   = r_fail_addr;
    assign FAIL_ELEM   = r_fail_elem;
    assign FAIL_SYND   = r_fail_synd;
    assign ERR_CNT     = r_err;
    assign A_BIST_EN   = r_busy;
    assign A_BIST_MEN  = r_men;
    assign A_BIST_WEN  = r_wen;
    assign A_BIST_REN  = r_ren;
    assign A_BIST_ADDR = r_baddr;
    assign A_BIST_DIN  = r_din;
    assign A_BIST_BM   = {P_DATA_WIDTH{r_busy}};
endmodule

// File: tb/tb_sram_1p_march_bist_ctrl.sv
// tb_sram_1p_march_bist_ctrl: directed bench with a behavioural 4-word macro and injectable faults.
module tb_sram_1p_march_bist_ctrl;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int N  = 4;
`ifdef BIST_CKBD_EN
    localparam int EW  = 4;
    localparam int LEN = 82;
`else
    localparam int EW  = 3;
    localparam int LEN = 42;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          BUSY, DONE, FAIL;
    logic [AW-1:0] FAIL_ADDR;
    logic [EW-1:0] FAIL_ELEM;
    logic [DW-1:0] FAIL_SYND;
    logic [7:0]    ERR_CNT;
    logic          A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN;
    logic [AW-1:0] A_BIST_ADDR;
    logic [DW-1:0] A_BIST_DIN, A_BIST_BM;
    logic [DW-1:0] a_dout = '0;
    logic [DW-1:0] mem [N];
    logic [12:0]   tr [6];
    logic [12:0]   tx [6];
    logic [DW-1:0] bm0;
    logic          en0;
    int            fault = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            len;

    sram_1p_march_bist_ctrl #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
        .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(start),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR),
        .FAIL_ELEM(FAIL_ELEM), .FAIL_SYND(FAIL_SYND), .ERR_CNT(ERR_CNT),
        .A_BIST_EN(A_BIST_EN), .A_BIST_MEN(A_BIST_MEN), .A_BIST_WEN(A_BIST_WEN),
        .A_BIST_REN(A_BIST_REN), .A_BIST_ADDR(A_BIST_ADDR), .A_BIST_DIN(A_BIST_DIN),
        .A_BIST_BM(A_BIST_BM), .A_DOUT(a_dout)
    );

    always #5 clk = ~clk;

    // fault 1: bit 3 of addr 2 stuck at 1; 2: writes to addr 1 also hit addr 3; 3: addr 0 bit 1 reads bit 0
    function automatic logic [DW-1:0] f_rd(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem[a];
        if (fault == 1 && a == 2'd2) d[3] = 1'b1;
        if (fault == 3 && a == 2'd0) d[1] = d[0];
        return d;
    endfunction

    always @(posedge clk) if (A_BIST_EN && A_BIST_MEN) begin
        if (A_BIST_WEN) begin
            mem[A_BIST_ADDR] <= (mem[A_BIST_ADDR] & ~A_BIST_BM) | (A_BIST_DIN & A_BIST_BM);
            if (fault == 2 && A_BIST_ADDR == 2'd1) mem[3] <= A_BIST_DIN;
        end else if (A_BIST_REN) a_dout <= f_rd(A_BIST_ADDR);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input int mid);
        len = 0;
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!BUSY) break;
            if (len < 6) tr[len] = {A_BIST_MEN, A_BIST_WEN, A_BIST_REN, A_BIST_ADDR, A_BIST_DIN};
            if (len == 0) begin
                bm0 = A_BIST_BM;
                en0 = A_BIST_EN;
            end
            len++;
            start = (len == mid);
        end
        start = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy_done_fail"}, {BUSY, DONE, FAIL}, 0);
        chk({tag, "_fail_rec"}, {FAIL_ADDR, FAIL_ELEM, FAIL_SYND}, 0);
        chk({tag, "_err"}, ERR_CNT, 0);
        chk({tag, "_ctl"}, {A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN}, 0);
        chk({tag, "_addr_din_bm"}, {A_BIST_ADDR, A_BIST_DIN, A_BIST_BM}, 0);
    endtask

    initial begin
        tx[0] = 13'h1800; tx[1] = 13'h1900; tx[2] = 13'h1A00;
        tx[3] = 13'h1B00; tx[4] = 13'h1400; tx[5] = 13'h18FF;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;

        run(-1);
        chk("clean_len", len, LEN);
        chk("clean_done", DONE, 1);
        chk("clean_fail", FAIL, 0);
        chk("clean_err", ERR_CNT, 0);
        for (int i = 0; i < 6; i++) chk($sformatf("trace%0d", i), tr[i], tx[i]);
        chk("run_bm_en", {bm0, en0}, {8'hFF, 1'b1});
        chk("done_ctl", {A_BIST_EN, A_BIST_MEN, A_BIST_BM}, 0);

`ifdef BIST_CKBD_EN
        fault = 3;
        run(-1);
        chk("ckbd_len", len, LEN);
        chk("ckbd_fail", FAIL, 1);
        chk("ckbd_addr", FAIL_ADDR, 0);
        chk("ckbd_elem", FAIL_ELEM, 4'b1001);
        chk("ckbd_synd", FAIL_SYND, 8'h02);
        chk("ckbd_err", ERR_CNT, 5);
`else
        fault = 2;
        run(-1);
        chk("dec_len", len, LEN);
        chk("dec_fail", FAIL, 1);
        chk("dec_addr", FAIL_ADDR, 3);
        chk("dec_elem", FAIL_ELEM, 1);
        chk("dec_synd", FAIL_SYND, 8'hFF);
        chk("dec_err", ERR_CNT, 2);

        fault = 1;
        run(-1);
        chk("sa1_fail", FAIL, 1);
        chk("sa1_addr", FAIL_ADDR, 2);
        chk("sa1_elem", FAIL_ELEM, 1);
        chk("sa1_synd", FAIL_SYND, 8'h08);
        chk("sa1_err", ERR_CNT, 3);

        fault = 0;
        run(20);
        chk("restart_len", len, LEN);
        chk("restart_done", DONE, 1);
        chk("restart_fail", FAIL, 0);
        chk("restart_err", ERR_CNT, 0);

        fault = 1;
        pulse_start();
        repeat (18) @(negedge clk);
        chk("pre_rst_fail", {FAIL, ERR_CNT}, {1'b1, 8'd1});
        chk("pre_rst_men", {BUSY, A_BIST_MEN}, 2'b11);
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        run(-1);
        chk("post_rst_len", len, LEN);
        chk("post_rst_done", DONE, 1);
        chk("post_rst_fail", {FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_SYND}, 0);
        chk("post_rst_err", ERR_CNT, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
